// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: opcode encoding, GPU command codes and queue entry layout.
package writeback_stage_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned LANE_WIDTH   = 16;
  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned VREG_WIDTH   = LANE_WIDTH * NUM_LANES;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OpNop            = 8'h00,
    OpAddD           = 8'h01,
    OpAddiD          = 8'h02,
    OpAddiF          = 8'h03,
    OpAndD           = 8'h04,
    OpAndiD          = 8'h05,
    OpMov            = 8'h06,
    OpMoviD          = 8'h07,
    OpMoviF          = 8'h08,
    OpJsr            = 8'h09,
    OpJsrr           = 8'h0A,
    OpLdw            = 8'h0B,
    OpStw            = 8'h0C,
    OpBr             = 8'h0D,
    OpJmp            = 8'h0E,
    OpVadd           = 8'h10,
    OpVmov           = 8'h11,
    OpVmovi          = 8'h12,
    OpVcompmov       = 8'h13,
    OpVcompmovi      = 8'h14,
    OpSetVertex      = 8'h20,
    OpSetColor       = 8'h21,
    OpRotate         = 8'h22,
    OpTranslate      = 8'h23,
    OpScale          = 8'h24,
    OpBeginPrimitive = 8'h25,
    OpEndPrimitive   = 8'h26,
    OpFlush          = 8'h27
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_VERTEX    = 4'd0,
    CMD_COLOR     = 4'd1,
    CMD_ROTATE    = 4'd2,
    CMD_TRANSLATE = 4'd3,
    CMD_SCALE     = 4'd4,
    CMD_BEGIN     = 4'd5,
    CMD_END       = 4'd6,
    CMD_FLUSH     = 4'd7
  } gpu_cmd_e;

  typedef struct packed {
    gpu_cmd_e                cmd;
    logic [1:0]              prim_type;
    logic [VREG_WIDTH-1:0]   payload;
  } gpu_entry_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/writeback_stage_gpu_cmd_fifo.sv
// GPU command queue: power-of-two depth, negedge clocked, with a sticky overflow flag.
module writeback_stage_gpu_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [Width-1:0] mem_q [Depth];
  logic             full, empty, rd_en, wr_en;

  assign full  = (count_q == (PtrW + 1)'(Depth));
  assign empty = (count_q == '0);
  assign rd_en = pop_i & ~empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign wr_en = push_i & (~full | rd_en);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_i & full & ~rd_en);
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(negedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o    = empty ? '0 : mem_q[rptr_q];
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registered scalar/vector register-file writes and GPU command queueing.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_WIDTH  = 16,
  parameter int unsigned VREG_WIDTH = 64
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [VREG_WIDTH-1:0]   I_ALUOutV,
  input  logic [VREG_WIDTH-1:0]   I_DestValueV,
  input  logic [3:0]              I_DestRegIdxV,
  input  logic [1:0]              I_DestRegIdxV_Idx,
  input  logic [1:0]              I_Type,
  output logic                    O_RegWE,
  output logic [3:0]              O_RegIdx,
  output logic [REG_WIDTH-1:0]    O_RegValue,
  output logic                    O_VRegWE,
  output logic [3:0]              O_VRegIdx,
  output logic [3:0]              O_VRegLaneMask,
  output logic [VREG_WIDTH-1:0]   O_VRegValue,
  output logic                    O_GpuValid,
  input  logic                    I_GpuReady,
  output logic [3:0]              O_GpuCmd,
  output logic [1:0]              O_GpuType,
  output logic [VREG_WIDTH-1:0]   O_GpuPayload,
  output logic                    O_GpuStall,
  output logic                    O_Overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                  accept;
  logic                  reg_we_d, reg_we_q;
  logic [3:0]            reg_idx_d, reg_idx_q;
  logic [REG_WIDTH-1:0]  reg_value_d, reg_value_q;
  logic                  vreg_we_d, vreg_we_q;
  logic [3:0]            vreg_idx_d, vreg_idx_q;
  logic [3:0]            vreg_mask_d, vreg_mask_q;
  logic [VREG_WIDTH-1:0] vreg_value_d, vreg_value_q;
  logic                  push;
  gpu_entry_t            push_entry, head;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty, gpu_pop;

  assign accept = I_LOCK & ~I_FetchStall & ~I_DepStall;

  always_comb begin
    reg_we_d     = 1'b0;
    reg_idx_d    = '0;
    reg_value_d  = '0;
    vreg_we_d    = 1'b0;
    vreg_idx_d   = '0;
    vreg_mask_d  = '0;
    vreg_value_d = '0;
    push         = 1'b0;
    push_entry   = '0;
    if (accept) begin
      case (opcode_e'(I_Opcode))
        OpAddD, OpAddiD, OpAddiF, OpAndD, OpAndiD, OpMov, OpMoviD, OpMoviF, OpJsr, OpJsrr: begin
          reg_we_d    = 1'b1;
          reg_idx_d   = I_DestRegIdx;
          reg_value_d = I_ALUOut;
        end
        OpLdw: begin
          reg_we_d    = 1'b1;
          reg_idx_d   = I_DestRegIdx;
          reg_value_d = I_MemOut;
        end
        OpVadd, OpVmov, OpVmovi: begin
          vreg_we_d    = 1'b1;
          vreg_idx_d   = I_DestRegIdxV;
          vreg_mask_d  = 4'b1111;
          vreg_value_d = I_ALUOutV;
        end
        OpVcompmov, OpVcompmovi: begin
          // Scalar is broadcast to every lane; the mask picks the one that lands.
          vreg_we_d    = 1'b1;
          vreg_idx_d   = I_DestRegIdxV;
          vreg_mask_d  = lane_onehot(I_DestRegIdxV_Idx);
          vreg_value_d = {NUM_LANES{I_ALUOut[LANE_WIDTH-1:0]}};
        end
        OpSetVertex, OpSetColor, OpRotate, OpTranslate, OpScale: begin
          push               = 1'b1;
          push_entry.payload = I_DestValueV;
          unique case (opcode_e'(I_Opcode))
            OpSetVertex: push_entry.cmd = CMD_VERTEX;
            OpSetColor:  push_entry.cmd = CMD_COLOR;
            OpRotate:    push_entry.cmd = CMD_ROTATE;
            OpTranslate: push_entry.cmd = CMD_TRANSLATE;
            default:     push_entry.cmd = CMD_SCALE;
          endcase
        end
        OpBeginPrimitive: begin
          push                 = 1'b1;
          push_entry.cmd       = CMD_BEGIN;
          push_entry.prim_type = I_Type;
        end
        OpEndPrimitive: begin
          push           = 1'b1;
          push_entry.cmd = CMD_END;
        end
        OpFlush: begin
          push           = 1'b1;
          push_entry.cmd = CMD_FLUSH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      reg_we_q     <= 1'b0;
      reg_idx_q    <= '0;
      reg_value_q  <= '0;
      vreg_we_q    <= 1'b0;
      vreg_idx_q   <= '0;
      vreg_mask_q  <= '0;
      vreg_value_q <= '0;
    end else begin
      reg_we_q     <= reg_we_d;
      reg_idx_q    <= reg_idx_d;
      reg_value_q  <= reg_value_d;
      vreg_we_q    <= vreg_we_d;
      vreg_idx_q   <= vreg_idx_d;
      vreg_mask_q  <= vreg_mask_d;
      vreg_value_q <= vreg_value_d;
    end
  end

  assign gpu_pop = ~fifo_empty & I_GpuReady;

  writeback_stage_gpu_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(gpu_entry_t))
  ) u_fifo (
    .clk_i      (I_CLOCK),
    .rst_ni     (I_RESET_N),
    .push_i     (push),
    .pop_i      (gpu_pop),
    .wdata_i    (push_entry),
    .rdata_o    (head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (O_Overflow)
  );

  assign O_RegWE        = reg_we_q;
  assign O_RegIdx       = reg_idx_q;
  assign O_RegValue     = reg_value_q;
  assign O_VRegWE       = vreg_we_q;
  assign O_VRegIdx      = vreg_idx_q;
  assign O_VRegLaneMask = vreg_mask_q;
  assign O_VRegValue    = vreg_value_q;

  assign O_GpuValid   = ~fifo_empty;
  assign O_GpuCmd     = head.cmd;
  assign O_GpuType    = head.prim_type;
  assign O_GpuPayload = head.payload;
  // Keep one slot free for the instruction already behind the stall.
  assign O_GpuStall   = fifo_full | (fifo_count == CntW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: vector table for register writes, scoreboard for the GPU queue.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        I_CLOCK, I_RESET_N, I_LOCK, I_FetchStall, I_DepStall;
  logic [7:0]  I_Opcode;
  logic [15:0] I_ALUOut, I_MemOut;
  logic [3:0]  I_DestRegIdx, I_DestRegIdxV;
  logic [63:0] I_ALUOutV, I_DestValueV;
  logic [1:0]  I_DestRegIdxV_Idx, I_Type;
  logic        O_RegWE, O_VRegWE, O_GpuValid, I_GpuReady, O_GpuStall, O_Overflow;
  logic [3:0]  O_RegIdx, O_VRegIdx, O_VRegLaneMask, O_GpuCmd;
  logic [15:0] O_RegValue;
  logic [63:0] O_VRegValue, O_GpuPayload;
  logic [1:0]  O_GpuType;

  int checks = 0;
  int errors = 0;
  logic [69:0] sb[$];

  writeback_stage dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall), .I_Opcode(I_Opcode),
    .I_ALUOut(I_ALUOut), .I_MemOut(I_MemOut), .I_DestRegIdx(I_DestRegIdx),
    .I_ALUOutV(I_ALUOutV), .I_DestValueV(I_DestValueV), .I_DestRegIdxV(I_DestRegIdxV),
    .I_DestRegIdxV_Idx(I_DestRegIdxV_Idx), .I_Type(I_Type),
    .O_RegWE(O_RegWE), .O_RegIdx(O_RegIdx), .O_RegValue(O_RegValue),
    .O_VRegWE(O_VRegWE), .O_VRegIdx(O_VRegIdx), .O_VRegLaneMask(O_VRegLaneMask),
    .O_VRegValue(O_VRegValue), .O_GpuValid(O_GpuValid), .I_GpuReady(I_GpuReady),
    .O_GpuCmd(O_GpuCmd), .O_GpuType(O_GpuType), .O_GpuPayload(O_GpuPayload),
    .O_GpuStall(O_GpuStall), .O_Overflow(O_Overflow)
  );

  initial begin
    I_CLOCK = 1'b1;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops happen on the negedge; checking the head mid-cycle keeps us off that edge.
  always @(posedge I_CLOCK) begin
    if (I_RESET_N && O_GpuValid && I_GpuReady) begin
      if (sb.size() == 0) begin
        check("gpu_unexpected_pop", {O_GpuCmd, O_GpuType, O_GpuPayload}, 128'h0);
        if (O_GpuCmd == 4'd0 && O_GpuType == 2'd0 && O_GpuPayload == 64'd0) begin
          errors++;
          $display("FAIL gpu_unexpected_pop: got zero entry expected none");
        end
      end else begin
        check("gpu_head", {O_GpuCmd, O_GpuType, O_GpuPayload}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  op;
    logic        lock, fs, ds;
    logic [3:0]  idx;
    logic [15:0] alu, mem;
    logic [3:0]  vidx;
    logic [1:0]  lane;
    logic [63:0] aluv;
    logic        e_we;
    logic [3:0]  e_idx;
    logic [15:0] e_val;
    logic        e_vwe;
    logic [3:0]  e_vidx, e_mask;
    logic [63:0] e_vval;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic gpu_push(input opcode_e op, input logic [1:0] typ, input logic [63:0] val,
                          input gpu_cmd_e ecmd, input logic [1:0] etyp, input logic [63:0] epay,
                          input bit keep);
    I_Opcode     = op;
    I_Type       = typ;
    I_DestValueV = val;
    if (keep) sb.push_back({ecmd, etyp, epay});
    step();
    I_Opcode = OpNop;
  endtask

  task automatic drain(input string name);
    I_GpuReady = 1'b1;
    for (int i = 0; i < 16 && O_GpuValid; i++) step();
    check({name, "_empty"}, O_GpuValid, 1'b0);
    check({name, "_sb"}, sb.size(), 0);
    check({name, "_stall"}, O_GpuStall, 1'b0);
    I_GpuReady = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{OpLdw,      1'b1, 1'b0, 1'b0, 4'd3,  16'h0010, 16'hBEEF, 4'd0,  2'd0, 64'h0,
                 1'b1, 4'd3,  16'hBEEF, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[1]  = '{OpAddD,     1'b1, 1'b0, 1'b0, 4'd7,  16'h1111, 16'h2222, 4'd0,  2'd0, 64'h0,
                 1'b1, 4'd7,  16'h1111, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[2]  = '{OpAddD,     1'b1, 1'b0, 1'b1, 4'd7,  16'h1111, 16'h2222, 4'd0,  2'd0, 64'h0,
                 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[3]  = '{OpMoviF,    1'b1, 1'b1, 1'b0, 4'd2,  16'h7777, 16'h0000, 4'd0,  2'd0, 64'h0,
                 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[4]  = '{OpJsrr,     1'b0, 1'b0, 1'b0, 4'd6,  16'h4321, 16'h0000, 4'd0,  2'd0, 64'h0,
                 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[5]  = '{OpVadd,     1'b1, 1'b0, 1'b0, 4'd1,  16'h5555, 16'h0000, 4'd9,  2'd1,
                 64'h0123456789ABCDEF,
                 1'b0, 4'd0,  16'h0000, 1'b1, 4'd9,  4'b1111, 64'h0123456789ABCDEF};
    vecs[6]  = '{OpVcompmovi, 1'b1, 1'b0, 1'b0, 4'd1, 16'h1234, 16'h0000, 4'd5,  2'd2,
                 64'hFFFFFFFFFFFFFFFF,
                 1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  4'b0100, 64'h1234123412341234};
    vecs[7]  = '{OpVcompmov, 1'b1, 1'b0, 1'b0, 4'd1,  16'hABCD, 16'h0000, 4'd15, 2'd0, 64'h0,
                 1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 4'b0001, 64'hABCDABCDABCDABCD};
    vecs[8]  = '{OpVcompmov, 1'b1, 1'b0, 1'b0, 4'd1,  16'h0F0F, 16'h0000, 4'd1,  2'd3, 64'h0,
                 1'b0, 4'd0,  16'h0000, 1'b1, 4'd1,  4'b1000, 64'h0F0F0F0F0F0F0F0F};
    vecs[9]  = '{OpStw,      1'b1, 1'b0, 1'b0, 4'd4,  16'h9999, 16'h8888, 4'd3,  2'd0, 64'h5,
                 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[10] = '{OpAndiD,    1'b1, 1'b0, 1'b0, 4'd0,  16'h00FF, 16'h1234, 4'd0,  2'd0, 64'h0,
                 1'b1, 4'd0,  16'h00FF, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[11] = '{OpJsr,      1'b1, 1'b0, 1'b0, 4'd15, 16'h8000, 16'h0001, 4'd0,  2'd0, 64'h0,
                 1'b1, 4'd15, 16'h8000, 1'b0, 4'd0,  4'b0000, 64'h0};
    vecs[12] = '{OpVmovi,    1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 16'h0000, 4'd2,  2'd0,
                 64'hDEADBEEFCAFEF00D,
                 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'b0000, 64'h0};

    I_RESET_N = 1'b0; I_LOCK = 1'b1; I_FetchStall = 1'b0; I_DepStall = 1'b0;
    I_Opcode = OpNop; I_ALUOut = '0; I_MemOut = '0; I_DestRegIdx = '0; I_ALUOutV = '0;
    I_DestValueV = '0; I_DestRegIdxV = '0; I_DestRegIdxV_Idx = '0; I_Type = '0;
    I_GpuReady = 1'b0;

    #12;
    check("rst_flags", {O_RegWE, O_VRegWE, O_GpuValid, O_GpuStall, O_Overflow}, 5'b0);
    check("rst_values", {O_RegIdx, O_RegValue, O_VRegIdx, O_VRegLaneMask, O_VRegValue}, 128'h0);
    check("rst_count", dut.u_fifo.count_o, 0);
    @(posedge I_CLOCK);
    #2 I_RESET_N = 1'b1;
    step();

    // Register-file writes, one instruction per cycle.
    I_DestValueV = 64'hFFFF0000FFFF0000;
    for (int i = 0; i < 13; i++) begin
      I_Opcode = vecs[i].op; I_LOCK = vecs[i].lock;
      I_FetchStall = vecs[i].fs; I_DepStall = vecs[i].ds;
      I_DestRegIdx = vecs[i].idx; I_ALUOut = vecs[i].alu; I_MemOut = vecs[i].mem;
      I_DestRegIdxV = vecs[i].vidx; I_DestRegIdxV_Idx = vecs[i].lane; I_ALUOutV = vecs[i].aluv;
      step();
      check($sformatf("vec%0d", i),
            {O_RegWE, O_RegIdx, O_RegValue, O_VRegWE, O_VRegIdx, O_VRegLaneMask, O_VRegValue},
            {vecs[i].e_we, vecs[i].e_idx, vecs[i].e_val, vecs[i].e_vwe, vecs[i].e_vidx,
             vecs[i].e_mask, vecs[i].e_vval});
    end
    I_LOCK = 1'b1; I_FetchStall = 1'b0; I_DepStall = 1'b0;

    // Strobe lasts one cycle.
    I_Opcode = OpLdw; I_MemOut = 16'h5A5A; I_DestRegIdx = 4'd9;
    step();
    check("we_pulse_on", {O_RegWE, O_RegValue}, {1'b1, 16'h5A5A});
    I_Opcode = OpNop;
    step();
    check("we_pulse_off", {O_RegWE, O_VRegWE}, 2'b00);
    check("no_push_from_regops", dut.u_fifo.count_o, 0);

    // Fill to full, then overflow.
    gpu_push(OpSetVertex, 2'd0, 64'h1111, CMD_VERTEX, 2'd0, 64'h1111, 1'b1);
    check("stall_after_1", {O_GpuValid, O_GpuStall}, 2'b10);
    gpu_push(OpSetVertex, 2'd0, 64'h2222, CMD_VERTEX, 2'd0, 64'h2222, 1'b1);
    check("stall_after_2", O_GpuStall, 1'b0);
    gpu_push(OpSetVertex, 2'd0, 64'h3333, CMD_VERTEX, 2'd0, 64'h3333, 1'b1);
    check("stall_after_3", {O_GpuStall, 3'(dut.u_fifo.count_o)}, {1'b1, 3'd3});
    gpu_push(OpSetColor, 2'd0, 64'h4444, CMD_COLOR, 2'd0, 64'h4444, 1'b1);
    check("full_no_ovf", {O_Overflow, O_GpuStall, 3'(dut.u_fifo.count_o)}, {1'b0, 1'b1, 3'd4});
    gpu_push(OpScale, 2'd0, 64'h5555, CMD_SCALE, 2'd0, 64'h5555, 1'b0);
    check("overflow_set", {O_Overflow, 3'(dut.u_fifo.count_o)}, {1'b1, 3'd4});
    check("head_kept", O_GpuPayload, 64'h1111);

    // Push and pop together while full.
    I_GpuReady = 1'b1;
    gpu_push(OpRotate, 2'd0, 64'h6666, CMD_ROTATE, 2'd0, 64'h6666, 1'b1);
    I_GpuReady = 1'b0;
    check("full_pushpop_count", dut.u_fifo.count_o, 4);
    check("full_pushpop_head", O_GpuPayload, 64'h2222);
    check("overflow_sticky", O_Overflow, 1'b1);
    drain("drain1");

    // Command mapping; bubble must not push.
    gpu_push(OpBeginPrimitive, 2'b10, 64'hFEED, CMD_BEGIN, 2'b10, 64'h0, 1'b1);
    gpu_push(OpEndPrimitive, 2'b11, 64'h1234, CMD_END, 2'b00, 64'h0, 1'b1);
    I_DepStall = 1'b1;
    gpu_push(OpSetVertex, 2'd0, 64'h7777, CMD_VERTEX, 2'd0, 64'h7777, 1'b0);
    I_DepStall = 1'b0;
    check("bubble_no_push", dut.u_fifo.count_o, 2);
    gpu_push(OpFlush, 2'b01, 64'hAAAA, CMD_FLUSH, 2'b00, 64'h0, 1'b1);
    gpu_push(OpTranslate, 2'b01, 64'h8888_0000_9999, CMD_TRANSLATE, 2'b00, 64'h8888_0000_9999,
             1'b1);
    check("map_full", {O_GpuStall, 3'(dut.u_fifo.count_o)}, {1'b1, 3'd4});
    drain("drain2");

    // Asynchronous reset flushes a queued command.
    gpu_push(OpBeginPrimitive, 2'b01, 64'h0, CMD_BEGIN, 2'b01, 64'h0, 1'b1);
    check("pre_reset", {O_GpuValid, O_Overflow}, 2'b11);
    @(posedge I_CLOCK);
    #2 I_RESET_N = 1'b0;
    #1;
    check("reset_flush", {O_GpuValid, O_Overflow, O_GpuStall}, 3'b000);
    check("reset_count", dut.u_fifo.count_o, 0);
    #1 I_RESET_N = 1'b1;
    sb.delete();
    step();

    gpu_push(OpSetColor, 2'd0, 64'hC0C0, CMD_COLOR, 2'd0, 64'hC0C0, 1'b1);
    check("post_reset_push", {O_GpuValid, 3'(dut.u_fifo.count_o)}, {1'b1, 3'd1});
    drain("drain3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
